// File: rtl/muldiv_sched.sv
// Sequencer for the EX-stage multiplier/divider: latches operands, drives the unit
// start handshakes, stalls EX while busy and holds the {hi,lo} result until advance.
module muldiv_sched #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        advance,
    input  logic        flush,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic        mul_ready,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        busy,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state, state_nx;
    logic [31:0]       a_q, b_q;
    logic              sgn_q;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       res_q;
    logic              to_q;
    logic              accept, in_unit, ready, to_hit;

    assign accept  = (state == IDLE) && req_valid && !flush;
    assign in_unit = (state == MUL) || (state == DIV);
    assign ready   = ((state == MUL) && mul_ready) || ((state == DIV) && div_ready);
    // Counter holds the number of completed busy cycles; this cycle is the last allowed one.
    assign to_hit  = (cnt >= CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_op[1])          state_nx = MUL;
                    else if (req_src2 != 0)  state_nx = DIV;
                    else                     state_nx = DONE;
                end
            end
            MUL, DIV: begin
                if (flush)        state_nx = IDLE;
                else if (ready)   state_nx = DONE;
                else if (to_hit)  state_nx = DONE;
            end
            DONE: begin
                if (flush || advance) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            cnt   <= '0;
            res_q <= '0;
            to_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                a_q   <= req_src1;
                b_q   <= req_src2;
                sgn_q <= !req_op[0];
                cnt   <= '0;
                to_q  <= 1'b0;
                if (req_op[1] && req_src2 == 0) res_q <= '0;
            end
            if (in_unit && !flush) begin
                if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
                // Ready wins over a simultaneous watchdog expiry.
                if (ready) begin
                    res_q <= (state == MUL) ? mul_result : div_result;
                end else if (to_hit) begin
                    res_q <= '0;
                    to_q  <= 1'b1;
                end
            end
        end
    end

    assign mul_start   = (state == MUL) && !mul_ready;
    assign mul_signed  = (state == MUL) && sgn_q;
    assign mul_ina     = (state == MUL) ? a_q : 32'd0;
    assign mul_inb     = (state == MUL) ? b_q : 32'd0;
    assign div_start   = (state == DIV) && !div_ready;
    assign div_signed  = (state == DIV) && sgn_q;
    assign div_opa     = (state == DIV) ? a_q : 32'd0;
    assign div_opb     = (state == DIV) ? b_q : 32'd0;
    assign div_annul   = (state == DIV) && (flush || (to_hit && !div_ready));
    assign stallreq    = accept || in_unit;
    assign busy        = (state != IDLE);
    assign res_valid   = (state == DONE);
    assign res_data    = res_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboard bench for muldiv_sched: the bench plays both arithmetic units and
// compares each held result against hand-derived expectations queued at issue.
module tb_muldiv_sched;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst, req_valid, advance, flush;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        mul_start, mul_signed, mul_ready;
    logic [31:0] mul_ina, mul_inb;
    logic [63:0] mul_result;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_opa, div_opb;
    logic [63:0] div_result;
    logic        stallreq, busy, res_valid, timeout_err;
    logic [63:0] res_data;

    int vectors = 0;
    int miscompares = 0;
    logic [64:0] sb_q[$];

    muldiv_sched #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_src1(req_src1), .req_src2(req_src2), .advance(advance), .flush(flush),
        .mul_start(mul_start), .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
        .mul_ready(mul_ready), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
        .div_annul(div_annul), .div_ready(div_ready), .div_result(div_result),
        .stallreq(stallreq), .busy(busy), .res_valid(res_valid), .res_data(res_data),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=hang exp=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] unit_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: return sa * sb;
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: return (b == 0) ? 64'd0 : {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
            default: return (b == 0) ? 64'd0 : {a % b, a / b};
        endcase
    endfunction

    // lat: start-high cycles before ready is raised; -1 means the unit never answers.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [63:0] exp_data,
                          input logic exp_to);
        logic is_mul, done, stall_bad, cross_bad, ops_bad, sgn_seen, hold_bad;
        logic [64:0] exp;
        int seen, annuls, exp_starts;
        is_mul = !op[1];
        done = 0; stall_bad = 0; cross_bad = 0; ops_bad = 0; sgn_seen = 0; hold_bad = 0;
        seen = 0; annuls = 0;
        exp_starts = (op[1] && b == 0) ? 0 : (lat < 0) ? TIMEOUT : lat;
        mul_result = is_mul ? unit_model(op, a, b) : 64'hDEAD_BEEF_DEAD_BEEF;
        div_result = is_mul ? 64'hBAD0_BAD0_BAD0_BAD0 : unit_model(op, a, b);

        @(negedge clk);
        req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
        sb_q.push_back({exp_to, exp_data});
        #1 chk({tag, "_accept_stall"}, stallreq, 1);

        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            mul_ready = 0; div_ready = 0;
            #1;
            if (res_valid) begin done = 1; break; end
            if (!stallreq) stall_bad = 1;
            if (seen == lat) begin
                if (is_mul) mul_ready = 1; else div_ready = 1;
            end
            #1;
            if (mul_start || div_start) seen++;
            if (div_annul) annuls++;
            if (mul_start) sgn_seen = mul_signed;
            if (div_start) sgn_seen = div_signed;
            if (is_mul ? (div_start || div_opa != 0 || div_opb != 0)
                       : (mul_start || mul_ina != 0 || mul_inb != 0)) cross_bad = 1;
            if ((mul_start && (mul_ina != a || mul_inb != b)) ||
                (div_start && (div_opa != a || div_opb != b))) ops_bad = 1;
        end
        mul_ready = 0; div_ready = 0;

        chk({tag, "_done"}, done, 1);
        exp = (sb_q.size() != 0) ? sb_q.pop_front() : 65'h0;
        chk({tag, "_res_data"}, res_data, exp[63:0]);
        chk({tag, "_timeout_err"}, timeout_err, exp[64]);
        chk({tag, "_start_cycles"}, seen, exp_starts);
        if (exp_starts != 0) chk({tag, "_signed"}, sgn_seen, !op[0]);
        chk({tag, "_stall_busy"}, stall_bad, 0);
        chk({tag, "_other_unit_idle"}, cross_bad, 0);
        chk({tag, "_operands"}, ops_bad, 0);
        chk({tag, "_annul_pulses"}, annuls, (!is_mul && lat < 0 && b != 0) ? 1 : 0);
        chk({tag, "_done_stall"}, stallreq, 0);

        // Hold DONE with the instruction still presented: nothing may restart.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (!res_valid || res_data != exp[63:0] || mul_start || div_start || stallreq)
                hold_bad = 1;
        end
        chk({tag, "_hold"}, hold_bad, 0);

        advance = 1;
        @(negedge clk);
        advance = 0; req_valid = 0;
        #1;
        chk({tag, "_idle_after_adv"}, busy, 0);
        chk({tag, "_valid_fall"}, res_valid, 0);
        chk({tag, "_data_kept"}, res_data, exp[63:0]);
    endtask

    initial begin
        int annuls;
        logic late_bad;
        rst = 1; req_valid = 0; req_op = 0; req_src1 = 0; req_src2 = 0;
        advance = 0; flush = 0; mul_ready = 0; div_ready = 0;
        mul_result = 0; div_result = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_starts", {mul_start, div_start, div_annul}, 0);
        chk("rst_operands", {mul_ina, mul_inb, div_opa, div_opb}, 0);
        rst = 0;

        run_op("mult",     2'b00, 32'hFFFF_FFFE, 32'd3,  4,  64'hFFFF_FFFF_FFFF_FFFA, 0);
        run_op("multu",    2'b01, 32'hFFFF_FFFE, 32'd3,  0,  64'h0000_0002_FFFF_FFFA, 0);
        run_op("divu",     2'b11, 32'd100,       32'd7,  33, 64'h0000_0002_0000_000E, 0);
        run_op("div_neg",  2'b10, 32'hFFFF_FF9C, 32'd7,  5,  64'hFFFF_FFFE_FFFF_FFF2, 0);
        run_op("div_zero", 2'b10, 32'd55,        32'd0,  3,  64'd0, 0);
        run_op("divu_edge",2'b11, 32'd1000,      32'd10, 63, 64'h0000_0000_0000_0064, 0);
        run_op("mul_to",   2'b00, 32'd9,         32'd9,  -1, 64'd0, 1);
        run_op("div_to",   2'b10, 32'd9,         32'd3,  -1, 64'd0, 1);

        // Flush during the tenth DIV cycle; a late ready must not resurrect the op.
        div_result = 64'h1234_5678_9ABC_DEF0;
        @(negedge clk);
        req_valid = 1; req_op = 2'b11; req_src1 = 32'd77; req_src2 = 32'd5;
        repeat (10) @(negedge clk);
        #1 chk("flush_pre_annul", div_annul, 0);
        flush = 1;
        #1 chk("flush_annul", div_annul, 1);
        annuls = 1;
        @(negedge clk);
        flush = 0; req_valid = 0;
        #1;
        chk("flush_idle", busy, 0);
        late_bad = 0;
        for (int c = 0; c < 4; c++) begin
            div_ready = 1;
            #1;
            if (div_annul) annuls++;
            if (res_valid || div_start || busy) late_bad = 1;
            @(negedge clk);
        end
        div_ready = 0;
        chk("flush_annul_once", annuls, 1);
        chk("flush_late_ready", late_bad, 0);
        chk("flush_data_kept", res_data, 64'd0);

        // Flush in IDLE blocks acceptance.
        req_valid = 1; req_op = 2'b00; req_src1 = 5; req_src2 = 6; flush = 1;
        #1 chk("idle_flush_stall", stallreq, 0);
        @(negedge clk);
        req_valid = 0; flush = 0;
        #1 chk("idle_flush_block", busy, 0);

        // Reset in the middle of a multiply.
        mul_result = 64'h0;
        @(negedge clk);
        req_valid = 1; req_op = 2'b00; req_src1 = 32'd11; req_src2 = 32'd13;
        repeat (3) @(negedge clk);
        #1 chk("rstmid_running", mul_start, 1);
        rst = 1; req_valid = 0;
        @(negedge clk);
        #1;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ctrl", {mul_start, mul_signed, stallreq, res_valid, timeout_err}, 0);
        chk("rstmid_operands", {mul_ina, mul_inb}, 0);
        chk("rstmid_res_data", res_data, 0);
        rst = 0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muldiv_sched.md
Name: muldiv_sched

Overview:
- Sequencer for the EX-stage multiplier and divider.
- Accepts one mul/div request per instruction from EX, latches the operands, and drives the start/ready handshake of the selected unit.
- Raises the EX stall request while the unit is busy, holds the 64-bit {hi,lo} result until the pipeline advances, and supports flush/annul.
- Replaces the ad-hoc per-unit combinational sequencing in EX; the result feeds the hilo write path.

Parameters:
- TIMEOUT, 64, maximum busy cycles before a watchdog abort.
- CNT_W, 7, width of the busy cycle counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  EX holds a mul/div instruction
- req_op  in  2  00 mult, 01 multu, 10 div, 11 divu
- req_src1  in  32  rs operand (multiplicand / dividend)
- req_src2  in  32  rt operand (multiplier / divisor)
- advance  in  1  EX stage advances this cycle (stall[2]==NoStop)
- flush  in  1  discard the in-flight operation
- mul_start  out  1  multiplier start, level
- mul_signed  out  1  signed multiply
- mul_ina  out  32  latched operand A
- mul_inb  out  32  latched operand B
- mul_ready  in  1  multiplier done
- mul_result  in  64  multiplier product
- div_start  out  1  divider start, level
- div_signed  out  1  signed divide
- div_opa  out  32  latched dividend
- div_opb  out  32  latched divisor
- div_annul  out  1  cancel divider
- div_ready  in  1  divider done
- div_result  in  64  {remainder, quotient}
- stallreq  out  1  stall request to the stall controller
- busy  out  1  state is not IDLE
- res_valid  out  1  result register valid
- res_data  out  64  {hi,lo} result
- timeout_err  out  1  last operation aborted by the watchdog

Behaviour:
- Reset (rst high at a posedge):
  - state = IDLE.
  - All outputs zero: operand registers, res_data, counter, timeout_err, res_valid.
  - Reset overrides flush and all other inputs; a mid-operation reset abandons the unit without waiting for ready.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - On req_valid: latch src1/src2 and the signed bit (op[0]==0 means signed); clear counter and timeout_err.
  - Op 00/01 goes to MUL.
  - Op 1x with req_src2 != 0 goes to DIV.
  - Op 1x with req_src2 == 0 goes directly to DONE with res_data = 0; the divider is never started.
- MUL / DIV:
  - The matching start output is high every cycle in this state; operands and signed are stable from latched registers.
  - The other unit's start stays 0 and its operands stay 0.
  - Counter increments each cycle.
  - On ready high: capture the result into res_data, go to DONE, drop start in that same cycle (start is combinational from state && !ready).
  - If the counter reaches TIMEOUT with no ready: res_data = 0, timeout_err = 1, go to DONE; div_annul pulses for one cycle when aborting DIV.
- DONE:
  - res_valid = 1; res_data is held.
  - req_valid is ignored, so the same instruction is never restarted.
  - On advance: go to IDLE; res_valid falls next cycle. res_data keeps its value until the next capture.
- stallreq (combinational):
  - 1 when (IDLE && req_valid && !flush), or in MUL or DIV.
  - 0 in DONE.
  - Minimum stall is 1 cycle (div by zero); otherwise latency is unit latency + 1.
- flush, any non-IDLE state:
  - Go to IDLE next cycle, res_valid = 0.
  - div_annul = 1 for that cycle if in DIV.
  - Ready arriving in the same cycle is ignored.
  - flush in IDLE blocks acceptance.
- Simultaneous ready and timeout: ready wins, timeout_err = 0.
- The counter saturates and never wraps.
- busy = (state != IDLE).

Test Plan:
- mult, src1 = 0xFFFFFFFE, src2 = 3, mul_ready after 4 cycles -> mul_start high for exactly 4 cycles, mul_signed = 1, stallreq high from the accept cycle until ready, res_data = 0xFFFFFFFF_FFFFFFFA held in DONE until advance.
- divu, src1 = 100, src2 = 7, div_ready after 33 cycles -> div_signed = 0, res_data = {32'd2, 32'd14}, res_valid high in DONE, state IDLE one cycle after advance.
- div, src2 = 0 -> no div_start; stallreq for 1 cycle; res_data = 0; res_valid = 1.
- mul_ready never asserted with TIMEOUT = 64 -> DONE after 64 busy cycles, timeout_err = 1, res_data = 0, stallreq released.
- flush during DIV cycle 10 -> div_annul pulses once, IDLE next cycle, a later ready is ignored, res_valid stays 0.
- DONE held with advance = 0 for 5 cycles while req_valid stays high -> no new start, res_data stable; rst asserted during MUL -> all outputs 0 next cycle.
